pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_pkg.sv | 9 +
 rtl/sync2.sv | 13 +
 rtl/pll_phase_ctrl.sv | 120 ++++++++++++
 tb/tb_pll_phase_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// pll_pkg: shared FSM encoding, phasestep levels and helpers for pll_phase_ctrl
package pll_pkg;
  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, IDLE, SETUP, PULSE, GAP} state_t;
  localparam logic STEP_IDLE = 1'b1;
  localparam logic STEP_ACTIVE = 1'b0;
  function automatic int maxi(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer (clk, reset, async d in, synchronized q out)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (reset) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: PLL reset/lock supervisor and dynamic phase-step sequencer with per-output phase tally
module pll_phase_ctrl
  import pll_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES = 4,
  parameter int PHASE_STEPS = 40,
  localparam int PW = $clog2(PHASE_STEPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_sel,
  input  logic                  req_dir,
  input  logic [7:0]            req_steps,
  output logic                  pll_rst,
  output logic [1:0]            phasesel,
  output logic                  phasedir,
  output logic                  phasestep,
  output logic                  clk_good,
  output logic                  busy,
  output logic [7:0]            relock_count,
  output logic [N_OUT*PW-1:0]   phase_pos
);
  localparam int CMAX = maxi(maxi(maxi(RST_CYCLES, LOCK_TIMEOUT), maxi(STABLE_CYCLES, SETUP_CYCLES)),
                             maxi(PULSE_CYCLES, GAP_CYCLES));
  localparam int CW = $clog2(CMAX + 1);
  state_t state;
  logic lk;
  logic relock;
  logic [CW-1:0] cnt;
  logic [7:0] rem;
  logic [PW-1:0] pos [N_OUT];
  sync2 u_sync (.clk(clk), .reset(reset), .d(pll_locked), .q(lk));
  for (genvar i = 0; i < N_OUT; i++) begin : g_pos
    assign phase_pos[i*PW +: PW] = pos[i];
  end
  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic up);
    return up ? (p == PW'(PHASE_STEPS - 1) ? '0 : p + 1'b1)
              : (p == '0 ? PW'(PHASE_STEPS - 1) : p - 1'b1);
  endfunction
  assign relock = !lk && (clk_good || (state == WAIT_LOCK && cnt == CW'(LOCK_TIMEOUT - 1)));
  always_ff @(posedge clk) begin
    if (reset || relock) begin
      state <= RST_PLL;
      cnt <= '0;
      pll_rst <= 1'b1;
      phasestep <= STEP_IDLE;
      req_ready <= 1'b0;
      clk_good <= 1'b0;
      busy <= 1'b0;
      for (int k = 0; k < N_OUT; k++) pos[k] <= '0;
      relock_count <= reset ? '0 : relock_count + 8'(relock_count != 8'hff);
      if (reset) begin
        phasesel <= '0;
        phasedir <= 1'b0;
        rem <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        RST_PLL: if (cnt == CW'(RST_CYCLES - 1)) begin
          state <= WAIT_LOCK;
          cnt <= '0;
          pll_rst <= 1'b0;
        end
        WAIT_LOCK: if (lk) begin
          state <= STABLE;
          cnt <= '0;
        end
        STABLE: if (!lk) cnt <= '0;
        else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state <= IDLE;
          cnt <= '0;
          req_ready <= 1'b1;
          clk_good <= 1'b1;
        end
        IDLE: begin
          cnt <= '0;
          if (req_valid && req_ready && int'(req_sel) < N_OUT && req_steps != '0) begin
            state <= SETUP;
            phasesel <= req_sel;
            phasedir <= req_dir;
            rem <= req_steps;
            req_ready <= 1'b0;
            busy <= 1'b1;
          end
        end
        SETUP: if (cnt == CW'(SETUP_CYCLES - 1)) begin
          state <= PULSE;
          cnt <= '0;
          phasestep <= STEP_ACTIVE;
        end
        PULSE: if (cnt == CW'(PULSE_CYCLES - 1)) begin
          state <= GAP;
          cnt <= '0;
          phasestep <= STEP_IDLE;
          for (int k = 0; k < N_OUT; k++)
            if (k == int'(phasesel)) pos[k] <= step_pos(pos[k], phasedir);
        end
        GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt <= '0;
          rem <= rem - 1'b1;
          state <= rem == 8'd1 ? IDLE : PULSE;
          phasestep <= rem == 8'd1 ? STEP_IDLE : STEP_ACTIVE;
          busy <= rem != 8'd1;
          req_ready <= rem == 8'd1;
        end
        default: state <= RST_PLL;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: scoreboard bench for pll_phase_ctrl lock supervision and phase stepping
module tb_pll_phase_ctrl;
  localparam int N_OUT = 2;
  localparam int PW = 6;
  localparam int TMO = 200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic req_valid = 1'b0;
  logic req_dir = 1'b0;
  logic [1:0] req_sel = '0;
  logic [7:0] req_steps = '0;
  logic req_ready, pll_rst, phasedir, phasestep, clk_good, busy;
  logic [1:0] phasesel;
  logic [7:0] relock_count;
  logic [N_OUT*PW-1:0] phase_pos;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int lat; int pulses; int lows; int highs; int sel; int pos; int relock;} exp_t;
  exp_t sbq[$];
  exp_t e;
  always #5 clk = ~clk;
  pll_phase_ctrl #(.N_OUT(N_OUT), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .pll_rst(pll_rst),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .clk_good(clk_good), .busy(busy), .relock_count(relock_count),
    .phase_pos(phase_pos)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int pp(input int p1, input int p0);
    return p1 * 64 + p0;
  endfunction
  task automatic request(input int sel, input bit dir, input int steps);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 5000) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("ready_wait_timeout", 0, 1);
    req_sel = 2'(sel);
    req_dir = dir;
    req_steps = 8'(steps);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  int cyc = 0, t_acc = 0, pulses = 0, lows = 0, highs = 0, psel = -1;
  logic acc_p = 1'b0, ready_prev = 1'b0, step_prev = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (acc_p) begin
      t_acc = cyc; pulses = 0; lows = 0; highs = 0; psel = -1;
    end
    if (busy) begin
      if (phasestep) highs++;
      else lows++;
    end
    if (!phasestep && step_prev) begin
      pulses++;
      psel = (psel == -1 || psel == int'(phasesel)) ? int'(phasesel) : -2;
    end
    if (req_ready && (!ready_prev || acc_p)) begin
      if (sbq.size() == 0) chk("unexpected_completion", 1, 0);
      else begin
        e = sbq.pop_front();
        if (e.lat >= 0) chk("latency", cyc - t_acc, e.lat);
        chk("pulses", pulses, e.pulses);
        if (e.lows >= 0) chk("low_cycles", lows, e.lows);
        if (e.highs >= 0) chk("busy_high_cycles", highs, e.highs);
        if (e.sel >= 0) chk("pulse_phasesel", psel, e.sel);
        chk("phase_pos", phase_pos, e.pos);
        chk("relock_count", relock_count, e.relock);
      end
      pulses = 0; lows = 0; highs = 0; psel = -1;
    end
    acc_p = req_valid && req_ready;
    ready_prev = req_ready;
    step_prev = phasestep;
  end
  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
  initial begin
    int n, m, k;
    logic prev;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pll_rst_phasestep", {pll_rst, phasestep}, 2'b11);
    chk("reset_sel_dir_ready_good_busy", {phasesel, phasedir, req_ready, clk_good, busy}, 0);
    chk("reset_relock_count", relock_count, 0);
    chk("reset_phase_pos", phase_pos, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int r = 1; r <= 3; r++) begin
      n = 0;
      while (pll_rst && n < 100) begin n++; @(negedge clk); end
      chk("rst_pulse_len", n, 16);
      n = 0;
      while (!pll_rst && n < TMO + 100) begin n++; @(negedge clk); end
      chk("lock_timeout_len", n, TMO);
      chk("relock_after_timeout", relock_count, r);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back('{-1, 0, -1, -1, -1, 0, 0});
    reset = 1'b0;
    @(negedge clk);
    n = 0;
    while (pll_rst && n < 100) begin n++; @(negedge clk); end
    chk("rst_pulse_len_locked", n, 16);
    m = n;
    while (!clk_good && m < 3000) begin m++; @(negedge clk); end
    chk("clk_good_delay", (m >= 1040 && m <= 1044) ? 1042 : m, 1042);
    chk("relock_after_clean_lock", relock_count, 0);
    sbq.push_back('{20, 3, 6, 14, 1, pp(3, 0), 0});
    request(1, 1'b1, 3);
    sbq.push_back('{8, 1, 2, 6, 0, pp(3, 39), 0});
    request(0, 1'b0, 1);
    sbq.push_back('{14, 2, 4, 10, 0, pp(3, 1), 0});
    request(0, 1'b1, 2);
    sbq.push_back('{224, 37, 74, 150, 1, pp(0, 1), 0});
    request(1, 1'b1, 37);
    sbq.push_back('{0, 0, 0, 0, -1, pp(0, 1), 0});
    request(3, 1'b0, 5);
    sbq.push_back('{0, 0, 0, 0, -1, pp(0, 1), 0});
    request(0, 1'b1, 0);
    sbq.push_back('{-1, 2, -1, -1, 1, 0, 1});
    request(1, 1'b1, 5);
    n = 0; k = 0; prev = 1'b1;
    while (k < 2 && n < 200) begin
      @(posedge clk); #1;
      if (!phasestep && prev) k++;
      prev = phasestep;
      n++;
    end
    chk("second_pulse_seen", k, 2);
    pll_locked = 1'b0;
    n = 0;
    while (!pll_rst && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_rst_latency", n <= 4 ? 4 : n, 4);
    chk("abort_relock_count", relock_count, 1);
    chk("abort_phase_pos_cleared", phase_pos, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    chk("scoreboard_drained", sbq.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (relock_count != 8'hff && n < 70000) begin @(posedge clk); #1; n++; end
    chk("relock_reaches_255", relock_count, 255);
    repeat (TMO + 40) @(posedge clk);
    #1;
    chk("relock_saturated", relock_count, 255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
